// File: rtl/spw_light_pkg.sv
// Shared definitions for the SpaceWire light Avalon slaves: register map,
// STATUS bit layout and the transmit character format.
package spw_light_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_STATUS  = 2'd1,
    ADDR_CONTROL = 2'd2,
    ADDR_DROPS   = 2'd3
  } reg_addr_e;

  localparam int STATUS_EMPTY_BIT  = 0;
  localparam int STATUS_FULL_BIT   = 1;
  localparam int STATUS_ENABLE_BIT = 2;
  localparam int STATUS_LEVEL_LSB  = 8;

  // Flag (EOP/EEP marker) plus one data byte.
  localparam int CHAR_W = 9;

  typedef struct packed {
    logic       flag;
    logic [7:0] data;
  } spw_char_t;

endpackage

// File: rtl/spw_light_txqueue_if.sv
// Avalon-MM slave port plus the character handshake toward the SpaceWire core.
// The master view is everything around the queue: the interconnect and the core.
interface spw_light_txqueue_if;

  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        txwrite;
  logic        txflag;
  logic [7:0]  txdata;
  logic        txrdy;

  modport master (
    output address, write, writedata, read, txrdy,
    input  readdata, txwrite, txflag, txdata
  );

  modport slave (
    input  address, write, writedata, read, txrdy,
    output readdata, txwrite, txflag, txdata
  );

endinterface

// File: rtl/spw_light_txqueue_fifo.sv
// Show-ahead FIFO: dout is a register holding the head entry, refreshed on
// push-into-empty and on pop, and held when the FIFO drains or is flushed.
module spw_light_txqueue_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 9
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2-1:0] rptr_next;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   remaining;
  logic                  do_push;
  logic                  do_pop;

  assign empty = (count == '0);
  assign full  = (count == FULL_LEVEL);
  assign level = count;

  // Full is the pre-edge value, so a push while full is dropped even with a pop.
  assign do_push   = push && !full && !flush;
  assign do_pop    = pop && !empty && !flush;
  assign rptr_next = rptr + DEPTH_LOG2'(do_pop);
  assign remaining = count - (DEPTH_LOG2 + 1)'(do_pop);

  // NOTE: the storage array is deliberately not reset; only pointers, level and
  // the head register are, so the array maps onto plain RAM without reset logic.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every reader
  // of wptr/rptr/count in this clock sees the pre-edge value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      dout  <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      rptr  <= rptr_next;
      count <= remaining + (DEPTH_LOG2 + 1)'(do_push);
      // The new head is the incoming word when nothing older survives this edge.
      if (do_push && remaining == '0)
        dout <= din;
      else if (do_pop && remaining != '0)
        dout <= mem[rptr_next];
    end
  end

endmodule

// File: rtl/spw_light_txqueue.sv
// Avalon-MM transmit queue for the SpaceWire light core: register decode,
// CONTROL/DROPS registers, registered read mux and the txwrite/txrdy glue.
module spw_light_txqueue
  import spw_light_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  spw_light_txqueue_if.slave  bus
);

  logic                wr_data;
  logic                wr_status;
  logic                wr_control;
  logic                wr_drops;
  logic                flush;
  logic                pop;
  logic                enable;
  logic [15:0]         drops;
  logic                fifo_empty;
  logic                fifo_full;
  logic [DEPTH_LOG2:0] fifo_level;
  spw_char_t           head;
  logic [31:0]         status_word;
  logic [31:0]         rd_mux;
  logic                unused_bits;

  assign wr_data    = bus.write && (bus.address == ADDR_DATA);
  assign wr_status  = bus.write && (bus.address == ADDR_STATUS);
  assign wr_control = bus.write && (bus.address == ADDR_CONTROL);
  assign wr_drops   = bus.write && (bus.address == ADDR_DROPS);
  assign flush      = wr_status && bus.writedata[0];
  assign pop        = bus.txwrite && bus.txrdy;

  // Reads have no side effects and the upper write-data bits carry nothing.
  assign unused_bits = ^{bus.read, bus.writedata[31:CHAR_W]};

  spw_light_txqueue_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (CHAR_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (wr_data),
    .pop     (pop),
    .flush   (flush),
    .din     (bus.writedata[CHAR_W-1:0]),
    .dout    (head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (fifo_level)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable <= 1'b0;
      drops  <= '0;
    end else begin
      if (wr_control) enable <= bus.writedata[0];
      if (wr_drops)
        drops <= '0;
      else if (wr_data && fifo_full && drops != 16'hFFFF)
        drops <= drops + 16'd1;
    end
  end

  // txwrite depends only on registers, so it stays put until txrdy pops.
  assign bus.txwrite = enable && !fifo_empty;
  assign bus.txflag  = head.flag;
  assign bus.txdata  = head.data;

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    status_word = '0;
    status_word[STATUS_EMPTY_BIT]         = fifo_empty;
    status_word[STATUS_FULL_BIT]          = fifo_full;
    status_word[STATUS_ENABLE_BIT]        = enable;
    status_word[STATUS_LEVEL_LSB +: 8]    = 8'(fifo_level);
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_STATUS:  rd_mux = status_word;
      ADDR_CONTROL: rd_mux = {31'd0, enable};
      ADDR_DROPS:   rd_mux = {16'd0, drops};
      default:      rd_mux = '0;
    endcase
  end

  // Captured every edge, whether or not read is asserted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus.readdata <= '0;
    else          bus.readdata <= rd_mux;
  end

endmodule

// File: tb/tb_spw_light_txqueue.sv
// Self-checking bench for spw_light_txqueue: directed vector table, corner
// sequences, then random traffic against a queue-based reference model.
module tb_spw_light_txqueue;
  import spw_light_pkg::*;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  spw_light_txqueue_if bus_if ();

  spw_light_txqueue #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  addr;
    logic        wr;
    logic        rd;
    logic [31:0] wd;
    logic        rdy;
    logic        exp_txw;
    logic [8:0]  exp_char;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [9];

  // Reference model state
  logic [8:0] mq [$];
  logic       m_en;
  int         m_drops;
  logic [8:0] m_head;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] a, input logic wr, input logic [31:0] wd,
                       input logic rd, input logic rdy);
    bus_if.address   = a;
    bus_if.write     = wr;
    bus_if.writedata = wd;
    bus_if.read      = rd;
    bus_if.txrdy     = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] chr(input int i);
    return 9'((i * 37 + 5) % 512);
  endfunction

  function automatic logic [31:0] m_reg(input logic [1:0] a);
    logic empty_b;
    logic full_b;
    empty_b = (mq.size() == 0);
    full_b  = (mq.size() == DEPTH);
    case (a)
      2'd1:    return {16'd0, 8'(mq.size()), 5'd0, m_en, full_b, empty_b};
      2'd2:    return {31'd0, m_en};
      2'd3:    return {16'd0, 16'(m_drops)};
      default: return 32'd0;
    endcase
  endfunction

  // One clock of the reference model followed by the DUT edge and comparison.
  task automatic model_cycle(input logic [1:0] a, input logic wr, input logic [31:0] wd,
                             input logic rdy);
    logic [31:0] exp_rd;
    logic        full_b;
    logic        txw;
    exp_rd = m_reg(a);
    full_b = (mq.size() == DEPTH);
    txw    = m_en && (mq.size() > 0);
    if (wr && a == 2'd1 && wd[0]) begin
      mq.delete();
    end else begin
      if (txw && rdy) void'(mq.pop_front());
      if (wr && a == 2'd0) begin
        if (full_b) begin
          if (m_drops < 65535) m_drops++;
        end else begin
          mq.push_back(wd[8:0]);
        end
      end
    end
    if (wr && a == 2'd2) m_en = wd[0];
    if (wr && a == 2'd3) m_drops = 0;
    if (mq.size() > 0) m_head = mq[0];
    drive(a, wr, wd, !wr, rdy);
    tick();
    check("rnd_txwrite", 32'(bus_if.txwrite), 32'(m_en && mq.size() > 0));
    check("rnd_char", 32'({bus_if.txflag, bus_if.txdata}), 32'(m_head));
    check("rnd_readdata", bus_if.readdata, exp_rd);
  endtask

  initial begin
    vecs[0] = '{2'd0, 1'b0, 1'b1, 32'h000, 1'b1, 1'b0, 9'h000, 32'h000};
    vecs[1] = '{2'd1, 1'b0, 1'b1, 32'h000, 1'b1, 1'b0, 9'h000, 32'h001};
    vecs[2] = '{2'd2, 1'b0, 1'b1, 32'h000, 1'b1, 1'b0, 9'h000, 32'h000};
    vecs[3] = '{2'd3, 1'b0, 1'b1, 32'h000, 1'b1, 1'b0, 9'h000, 32'h000};
    vecs[4] = '{2'd2, 1'b1, 1'b0, 32'h001, 1'b1, 1'b0, 9'h000, 32'h000};
    vecs[5] = '{2'd0, 1'b1, 1'b0, 32'h155, 1'b1, 1'b1, 9'h155, 32'h000};
    vecs[6] = '{2'd0, 1'b1, 1'b0, 32'h042, 1'b1, 1'b1, 9'h042, 32'h000};
    vecs[7] = '{2'd1, 1'b0, 1'b1, 32'h000, 1'b1, 1'b0, 9'h042, 32'h104};
    vecs[8] = '{2'd1, 1'b0, 1'b1, 32'h000, 1'b1, 1'b0, 9'h042, 32'h005};

    reset_n = 1'b0;
    drive(2'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_txwrite", 32'(bus_if.txwrite), 32'd0);
    check("reset_char", 32'({bus_if.txflag, bus_if.txdata}), 32'd0);
    check("reset_readdata", bus_if.readdata, 32'd0);
    reset_n = 1'b1;

    // Directed vector table: reset reads, enable, two characters back to back
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].addr, vecs[i].wr, vecs[i].wd, vecs[i].rd, vecs[i].rdy);
      tick();
      check($sformatf("vec%0d_txwrite", i), 32'(bus_if.txwrite), 32'(vecs[i].exp_txw));
      check($sformatf("vec%0d_char", i), 32'({bus_if.txflag, bus_if.txdata}), 32'(vecs[i].exp_char));
      check($sformatf("vec%0d_readdata", i), bus_if.readdata, vecs[i].exp_rd);
    end

    // Overfill with the core stalled: 17 pushes, one dropped
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(2'd0, 1'b1, 32'(chr(i)), 1'b0, 1'b0);
      tick();
    end
    drive(2'd1, 1'b0, 32'd0, 1'b1, 1'b0);
    tick();
    check("fill_status", bus_if.readdata, 32'h0000_1006);
    drive(2'd3, 1'b0, 32'd0, 1'b1, 1'b0);
    tick();
    check("fill_drops", bus_if.readdata, 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain%0d_txwrite", i), 32'(bus_if.txwrite), 32'd1);
      check($sformatf("drain%0d_char", i), 32'({bus_if.txflag, bus_if.txdata}), 32'(chr(i)));
      drive(2'd1, 1'b0, 32'd0, 1'b1, 1'b1);
      tick();
    end
    check("drain_done_txwrite", 32'(bus_if.txwrite), 32'd0);
    tick();
    check("drain_done_status", bus_if.readdata, 32'h0000_0005);

    // Stall: txrdy low for 10 cycles, head must hold; then disable
    drive(2'd0, 1'b1, 32'(chr(20)), 1'b0, 1'b0);
    tick();
    drive(2'd0, 1'b1, 32'(chr(21)), 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(2'd1, 1'b0, 32'd0, 1'b1, 1'b0);
      tick();
      check($sformatf("stall%0d_txwrite", k), 32'(bus_if.txwrite), 32'd1);
      check($sformatf("stall%0d_char", k), 32'({bus_if.txflag, bus_if.txdata}), 32'(chr(20)));
    end
    drive(2'd2, 1'b1, 32'd0, 1'b0, 1'b0);
    tick();
    check("disable_txwrite", 32'(bus_if.txwrite), 32'd0);
    drive(2'd1, 1'b0, 32'd0, 1'b1, 1'b0);
    tick();
    check("disable_status", bus_if.readdata, 32'h0000_0200);

    // Flush with 3 entries queued; a push lands in the cycle just before
    drive(2'd2, 1'b1, 32'd1, 1'b0, 1'b0);
    tick();
    drive(2'd0, 1'b1, 32'(chr(22)), 1'b0, 1'b0);
    tick();
    drive(2'd1, 1'b1, 32'h0000_0001, 1'b0, 1'b1);
    tick();
    check("flush_txwrite", 32'(bus_if.txwrite), 32'd0);
    check("flush_hold_char", 32'({bus_if.txflag, bus_if.txdata}), 32'(chr(20)));
    drive(2'd1, 1'b0, 32'd0, 1'b1, 1'b0);
    tick();
    check("flush_status", bus_if.readdata, 32'h0000_0005);
    drive(2'd3, 1'b0, 32'd0, 1'b1, 1'b0);
    tick();
    check("flush_drops", bus_if.readdata, 32'd1);
    drive(2'd3, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    tick();
    drive(2'd3, 1'b0, 32'd0, 1'b1, 1'b0);
    tick();
    check("drops_clear", bus_if.readdata, 32'd0);

    // Asynchronous reset mid-stream with 5 entries queued
    for (int i = 30; i < 35; i++) begin
      drive(2'd0, 1'b1, 32'(chr(i)), 1'b0, 1'b0);
      tick();
    end
    drive(2'd2, 1'b0, 32'd0, 1'b1, 1'b0);
    tick();
    check("prereset_txwrite", 32'(bus_if.txwrite), 32'd1);
    check("prereset_readdata", bus_if.readdata, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_txwrite", 32'(bus_if.txwrite), 32'd0);
    check("async_char", 32'({bus_if.txflag, bus_if.txdata}), 32'd0);
    check("async_readdata", bus_if.readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(2'd1, 1'b0, 32'd0, 1'b1, 1'b0);
    tick();
    check("postreset_status", bus_if.readdata, 32'h0000_0001);
    drive(2'd2, 1'b0, 32'd0, 1'b1, 1'b0);
    tick();
    check("postreset_enable", bus_if.readdata, 32'd0);

    // Random traffic against the reference model, starting from reset state
    mq.delete();
    m_en    = 1'b0;
    m_drops = 0;
    m_head  = 9'd0;
    for (int n = 0; n < 3000; n++) begin
      int          r;
      logic [1:0]  a;
      logic        wr;
      logic [31:0] wd;
      logic        rdy;
      r   = int'($urandom_range(0, 99));
      wd  = $urandom;
      rdy = ((n / 200) % 2 == 1) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
      if (r < 50) begin
        a = 2'd0; wr = 1'b1;
      end else if (r < 52) begin
        a = 2'd1; wr = 1'b1;
      end else if (r < 58) begin
        a = 2'd2; wr = 1'b1; wd[0] = ($urandom_range(0, 4) != 0);
      end else if (r < 60) begin
        a = 2'd3; wr = 1'b1;
      end else begin
        a = 2'($urandom_range(0, 3)); wr = 1'b0;
      end
      model_cycle(a, wr, wd, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
